// File: rtl/cobra_pkg.sv
// Shared definitions for the cobra core: instruction layout, write-back
// selects, FSM states and ALU opcodes.
package cobra_pkg;

  localparam int INSTR_W  = 32;
  localparam int B_BIT    = 31;
  localparam int C_BIT    = 30;
  localparam int WS_HI    = 29;
  localparam int WS_LO    = 28;
  localparam int OP_HI    = 27;
  localparam int OP_LO    = 23;
  localparam int RA1_HI   = 22;
  localparam int RA1_LO   = 18;
  localparam int RA2_HI   = 17;
  localparam int RA2_LO   = 13;
  localparam int OFFS_HI  = 12;
  localparam int OFFS_LO  = 5;
  localparam int WA_HI    = 4;
  localparam int WA_LO    = 0;
  localparam int CONST_HI = 27;
  localparam int CONST_LO = 5;

  typedef enum logic [1:0] {
    WS_NONE  = 2'd0,
    WS_IN    = 2'd1,
    WS_CONST = 2'd2,
    WS_ALU   = 2'd3
  } ws_e;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_WAIT_IN = 2'd1,
    S_HALT    = 2'd2
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b01000;
  localparam logic [4:0] OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_SLT  = 5'b00010;
  localparam logic [4:0] OP_SLTU = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SRA  = 5'b01101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_BEQ  = 5'b11000;
  localparam logic [4:0] OP_BNE  = 5'b11001;
  localparam logic [4:0] OP_BLT  = 5'b11100;
  localparam logic [4:0] OP_BGE  = 5'b11101;
  localparam logic [4:0] OP_BLTU = 5'b11110;
  localparam logic [4:0] OP_BGEU = 5'b11111;

  // Field view of an instruction; CONST overlays op/ra1/ra2/offs.
  typedef struct packed {
    logic       b;
    logic       c;
    ws_e        ws;
    logic [4:0] op;
    logic [4:0] ra1;
    logic [4:0] ra2;
    logic [7:0] offs;
    logic [4:0] wa;
  } instr_t;

endpackage

// File: rtl/alu_riscv.sv
// RISC-V style combinational ALU; flag is only driven by the compare opcodes.
module alu_riscv
  import cobra_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [4:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] res_o,
  output logic         flag_o
);

  localparam int SH_W = $clog2(W);
  logic [SH_W-1:0] sh;
  assign sh = b_i[SH_W-1:0];

  always_comb begin
    res_o  = '0;
    flag_o = 1'b0;
    case (op_i)
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_SLL:  res_o = a_i << sh;
      OP_SLT:  res_o = {{(W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: res_o = {{(W-1){1'b0}}, (a_i < b_i)};
      OP_XOR:  res_o = a_i ^ b_i;
      OP_SRL:  res_o = a_i >> sh;
      OP_SRA:  res_o = $signed(a_i) >>> sh;
      OP_OR:   res_o = a_i | b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_BEQ:  flag_o = (a_i == b_i);
      OP_BNE:  flag_o = (a_i != b_i);
      OP_BLT:  flag_o = ($signed(a_i) <  $signed(b_i));
      OP_BGE:  flag_o = ($signed(a_i) >= $signed(b_i));
      OP_BLTU: flag_o = (a_i <  b_i);
      OP_BGEU: flag_o = (a_i >= b_i);
      default: ;
    endcase
  end

endmodule

// File: rtl/cobra_regfile.sv
// 2R1W register file, synchronous clear, r0 and out-of-range addresses read 0.
module cobra_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        ra1_i,
  input  logic [4:0]        ra2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  input  logic              we_i,
  input  logic [4:0]        wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] regs_q [REG_N];

  for (genvar g = 0; g < REG_N; g++) begin : g_reg
    if (g == 0) begin : g_zero
      assign regs_q[0] = '0;
    end else begin : g_store
      always_ff @(posedge clk_i) begin
        if (rst_i)                         regs_q[g] <= '0;
        else if (we_i && wa_i == 5'(g))    regs_q[g] <= wd_i;
      end
    end
  end

  // No bypass: a same-cycle write is not visible on the read ports.
  always_comb begin
    rd1_o = '0;
    rd2_o = '0;
    for (int i = 1; i < REG_N; i++) begin
      if (ra1_i == 5'(i)) rd1_o = regs_q[i];
      if (ra2_i == 5'(i)) rd2_o = regs_q[i];
    end
  end

endmodule

// File: rtl/cobra_core_hs.sv
// Single-issue programmable core with handshaked input, registered output
// and a terminal HALT state.
module cobra_core_hs
  import cobra_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int REG_N  = 32
) (
  input  logic              CLK,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted
);

  state_e            state_q;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] out_q;
  logic              outv_q, halted_q;

  instr_t            ins;
  logic [DATA_W-1:0] rd1, rd2, alu_res, wd, const_sext;
  logic [PC_W-1:0]   offs_sext;
  logic              alu_flag, active, in_stall, commit, jump, halt_hit;

  assign ins        = instr_t'(imem_rdata);
  assign const_sext = DATA_W'($signed(imem_rdata[CONST_HI:CONST_LO]));
  assign offs_sext  = PC_W'($signed(ins.offs));

  // WAIT_IN re-presents the same instruction, so the stall test is shared.
  assign active   = (state_q == S_RUN) || (state_q == S_WAIT_IN);
  assign in_stall = (ins.ws == WS_IN) && !in_valid;
  assign commit   = active && !in_stall;
  assign in_ready = !rst && active && (ins.ws == WS_IN) &&
                    (in_valid || state_q == S_WAIT_IN);

  assign jump     = ins.b | (ins.c & alu_flag);
  assign halt_hit = ins.b && (ins.offs == 8'd0);
  assign pc_d     = jump ? pc_q + offs_sext : pc_q + PC_W'(1);

  always_comb begin
    wd = '0;
    case (ins.ws)
      WS_IN:    wd = in_data;
      WS_CONST: wd = const_sext;
      WS_ALU:   wd = alu_res;
      default:  wd = '0;
    endcase
  end

  alu_riscv #(.W(DATA_W)) u_alu (
    .op_i   (ins.op),
    .a_i    (rd1),
    .b_i    (rd2),
    .res_o  (alu_res),
    .flag_o (alu_flag)
  );

  cobra_regfile #(.DATA_W(DATA_W), .REG_N(REG_N)) u_rf (
    .clk_i (CLK),
    .rst_i (rst),
    .ra1_i (ins.ra1),
    .ra2_i (ins.ra2),
    .rd1_o (rd1),
    .rd2_o (rd2),
    .we_i  (commit && ins.ws != WS_NONE),
    .wa_i  (ins.wa),
    .wd_i  (wd)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q  <= S_RUN;
      pc_q     <= '0;
      out_q    <= '0;
      outv_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      outv_q <= 1'b0;
      case (state_q)
        S_RUN, S_WAIT_IN: begin
          if (in_stall) begin
            state_q <= S_WAIT_IN;
          end else begin
            if (ins.ws == WS_ALU) begin
              out_q  <= alu_res;
              outv_q <= 1'b1;
            end
            if (halt_hit) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
              pc_q    <= pc_d;
            end
          end
        end
        S_HALT:  ;
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign out_data  = out_q;
  assign out_valid = outv_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cobra_core_hs.sv
// Directed and random program runs against an instruction-level model.
module tb_cobra_core_hs;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        halted;

  logic [31:0] mem [256];
  assign imem_rdata = mem[imem_addr];

  always #5 CLK = ~CLK;

  cobra_core_hs #(.DATA_W(32), .PC_W(8), .REG_N(32)) dut (
    .CLK(CLK), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .halted(halted)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural state only
  logic [7:0]  m_pc;
  logic [31:0] m_r [32];
  logic        m_wait, m_halt, m_outv;
  logic [31:0] m_out;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b01000, SLL = 5'b00001, SLT = 5'b00010,
                         SLTU = 5'b00011, XOR = 5'b00100, SRL = 5'b00101, SRA = 5'b01101,
                         OR = 5'b00110, AND = 5'b00111, BEQ = 5'b11000, BNE = 5'b11001,
                         BLT = 5'b11100, BGE = 5'b11101, BLTU = 5'b11110, BGEU = 5'b11111;
  logic [4:0] ops [16] = '{ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
                           BEQ, BNE, BLT, BGE, BLTU, BGEU};

  function automatic void m_alu(input logic [4:0] op, input logic [31:0] a, b,
                                output logic [31:0] r, output logic f);
    r = 0; f = 0;
    case (op)
      ADD:  r = a + b;
      SUB:  r = a - b;
      SLL:  r = a << b[4:0];
      SLT:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      SLTU: r = (a < b) ? 1 : 0;
      XOR:  r = a ^ b;
      SRL:  r = a >> b[4:0];
      SRA:  r = $signed(a) >>> b[4:0];
      OR:   r = a | b;
      AND:  r = a & b;
      BEQ:  f = (a == b);
      BNE:  f = (a != b);
      BLT:  f = $signed(a) < $signed(b);
      BGE:  f = $signed(a) >= $signed(b);
      BLTU: f = a < b;
      BGEU: f = a >= b;
      default: ;
    endcase
  endfunction

  function automatic logic m_ready(input logic v);
    logic [31:0] w;
    w = mem[m_pc];
    return !m_halt && (w[29:28] == 2'd1) && (v || m_wait);
  endfunction

  task automatic m_reset();
    m_pc = 0; m_wait = 0; m_halt = 0; m_outv = 0; m_out = 0;
    for (int i = 0; i < 32; i++) m_r[i] = 0;
  endtask

  task automatic m_exec(input logic v, input logic [31:0] d);
    logic [31:0] w, a, b, r, wv;
    logic f;
    m_outv = 0;
    if (m_halt) return;
    w = mem[m_pc];
    if (w[29:28] == 2'd1 && !v) begin m_wait = 1; return; end
    m_wait = 0;
    a = m_r[w[22:18]];
    b = m_r[w[17:13]];
    m_alu(w[27:23], a, b, r, f);
    case (w[29:28])
      2'd1:    wv = d;
      2'd2:    wv = {{9{w[27]}}, w[27:5]};
      default: wv = r;
    endcase
    if (w[29:28] != 0 && w[4:0] != 0) m_r[w[4:0]] = wv;
    if (w[29:28] == 2'd3) begin m_out = r; m_outv = 1; end
    if (w[31] && w[12:5] == 0) m_halt = 1;
    else if (w[31] || (w[30] && f)) m_pc = m_pc + w[12:5];
    else m_pc = m_pc + 1;
  endtask

  // One clock: drive at negedge, check ready, clock, check state.
  task automatic step(input logic v, input logic [31:0] d);
    in_valid = v; in_data = d;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready(v)});
    m_exec(v, d);
    @(posedge CLK); #1;
    chk("pc", {24'd0, imem_addr}, {24'd0, m_pc});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_outv});
    chk("out_data", out_data, m_out);
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    @(negedge CLK);
  endtask

  task automatic do_reset(input int n);
    rst = 1; in_valid = 0;
    m_reset();
    repeat (n) begin
      @(posedge CLK); #1;
      chk("rst_pc", {24'd0, imem_addr}, 32'd0);
      chk("rst_outv", {31'd0, out_valid}, 32'd0);
      chk("rst_out", out_data, 32'd0);
      chk("rst_halt", {31'd0, halted}, 32'd0);
      @(negedge CLK);
    end
    rst = 0;
  endtask

  function automatic logic [31:0] mk(input logic b, c, input logic [1:0] ws, input logic [4:0] op,
                                     input logic [4:0] ra1, ra2, input logic [7:0] offs,
                                     input logic [4:0] wa);
    return {b, c, ws, op, ra1, ra2, offs, wa};
  endfunction

  function automatic logic [31:0] mkc(input logic [22:0] k, input logic [4:0] wa);
    return {2'b00, 2'd2, k, wa};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    w[31] = ($urandom_range(0, 7) == 0);
    if (w[29:28] == 2'd3) w[27:23] = ops[$urandom_range(0, 9)];
    else if (w[29:28] != 2'd2) w[27:23] = ops[$urandom_range(0, 15)];
    if (w[29:28] != 2'd2) begin w[22:21] = 0; w[17:16] = 0; end
    w[4:3] = 0;
    if ($urandom_range(0, 63) == 0) begin w[31] = 1; w[12:5] = 0; end
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 0;
    mem[0]  = mkc(23'd5, 5'd1);
    mem[1]  = mkc(23'h7FFFFF, 5'd2);
    mem[2]  = mk(0, 0, 2'd3, ADD, 5'd1, 5'd1, 8'd0, 5'd3);
    mem[4]  = mk(0, 0, 2'd3, ADD, 5'd1, 5'd2, 8'd0, 5'd0);
    mem[5]  = mk(0, 0, 2'd3, ADD, 5'd0, 5'd0, 8'd0, 5'd0);
    mem[6]  = mk(0, 0, 2'd1, ADD, 5'd0, 5'd0, 8'd0, 5'd4);
    mem[7]  = mk(0, 0, 2'd3, ADD, 5'd4, 5'd0, 8'd0, 5'd0);
    mem[8]  = mk(0, 0, 2'd1, ADD, 5'd0, 5'd0, 8'd0, 5'd5);
    mem[9]  = mkc(23'd5, 5'd2);
    mem[10] = mk(0, 1, 2'd0, BEQ, 5'd1, 5'd2, 8'hFE, 5'd0);
    mem[11] = mk(0, 0, 2'd1, ADD, 5'd0, 5'd0, 8'd0, 5'd7);
    do_reset(2);

    // constants, ALU write-back, r0 discard
    step(0, 0); chk("t1_pc1", {24'd0, imem_addr}, 32'd1); chk("t1_ov0", {31'd0, out_valid}, 0);
    step(0, 0); chk("t1_pc2", {24'd0, imem_addr}, 32'd2);
    step(0, 0); chk("t2_add", out_data, 32'd10); chk("t2_ov1", {31'd0, out_valid}, 1);
    step(0, 0); chk("t2_ov_pulse", {31'd0, out_valid}, 0);
    step(0, 0); chk("t2_sext", out_data, 32'd4);
    step(0, 0); chk("t2_r0", out_data, 32'd0); chk("t2_r0_ov", {31'd0, out_valid}, 1);

    // input stall then handshake
    repeat (3) begin
      step(0, 32'hDEAD);
      chk("t3_hold", {24'd0, imem_addr}, 32'd6);
      chk("t3_rdy", {31'd0, in_ready}, 1);
    end
    step(1, 32'h1234); chk("t3_adv", {24'd0, imem_addr}, 32'd7);
    step(0, 0); chk("t3_r4", out_data, 32'h1234);
    step(1, 32'hABCD); chk("t3_nostall", {24'd0, imem_addr}, 32'd9);

    // branches
    step(0, 0);
    step(0, 0); chk("t4_beq", {24'd0, imem_addr}, 32'd8);
    mem[10] = mk(0, 1, 2'd0, BNE, 5'd1, 5'd2, 8'hFE, 5'd0);
    step(1, 32'h77); step(0, 0);
    step(0, 0); chk("t4_bne", {24'd0, imem_addr}, 32'd11);

    // reset while waiting for input
    step(0, 0); step(0, 0); chk("t6_wait", {31'd0, in_ready}, 1);
    mem[0] = mk(0, 0, 2'd1, ADD, 5'd0, 5'd0, 8'd0, 5'd7);
    mem[1] = mk(0, 0, 2'd3, ADD, 5'd4, 5'd1, 8'd0, 5'd0);
    do_reset(1);
    #1; chk("t6_rdy0", {31'd0, in_ready}, 0);
    step(1, 32'h55);
    step(0, 0); chk("t6_regs0", out_data, 32'd0);

    // wrap and halt
    for (int i = 0; i < 256; i++) mem[i] = 0;
    mem[0]   = mk(1, 0, 2'd0, ADD, 5'd0, 5'd0, 8'hFE, 5'd0);
    mem[254] = mk(1, 0, 2'd0, ADD, 5'd0, 5'd0, 8'd3, 5'd0);
    mem[1]   = mk(1, 0, 2'd0, ADD, 5'd0, 5'd0, 8'd5, 5'd0);
    mem[6]   = mk(1, 0, 2'd3, ADD, 5'd0, 5'd0, 8'd0, 5'd0);
    do_reset(1);
    step(0, 0); chk("t4_back", {24'd0, imem_addr}, 32'd254);
    step(0, 0); chk("t4_wrap", {24'd0, imem_addr}, 32'd1);
    step(0, 0); chk("t5_pc6", {24'd0, imem_addr}, 32'd6);
    step(0, 0); chk("t5_halt", {31'd0, halted}, 1); chk("t5_wb", {31'd0, out_valid}, 1);
    repeat (20) step($urandom_range(0, 1), $urandom);
    chk("t5_hold", {24'd0, imem_addr}, 32'd6);
    do_reset(1);
    chk("t5_unhalt", {31'd0, halted}, 0);

    // random programs
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = rnd_instr();
      do_reset(1);
      for (int c = 0; c < 400; c++) begin
        if (m_halt && $urandom_range(0, 9) == 0) do_reset(1);
        else step($urandom_range(0, 1), $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
